gate_truth_checker: RTL
=======================

// Module: gate_truth_checker
// PURPOSE
//  Self-timed exhaustive stimulus/checker for a 2-input gate under test (GUT), e.g. a switch-level NAND.
//  Sits directly around the GUT: drives its inputs a/b (upstream) and samples its output f (downstream).
//  Walks all four {a,b} combinations, waits a settle window per vector, compares f to an expected truth table.
//  Accumulates mismatches; reports done/pass.
// PARAMETERS
//  EXP_TABLE      4'b0111  expected f, indexed by {a,b} (bit0 = 00 ... bit3 = 11); default = NAND
//  SETTLE_CYCLES  2        cycles a vector is held before sampling; legal range >= 1
//  NUM_PASSES     1        full 4-vector sweeps per run; legal range >= 1
//  ERR_W          8        width of the mismatch counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      run request, sampled in IDLE or DONE only
//  dut_a      out  1      GUT input a (registered)
//  dut_b      out  1      GUT input b (registered)
//  dut_f      in   1      GUT output; 0/1/x/z possible
//  busy       out  1      run in progress
//  done       out  1      run complete; level, held until next start
//  pass       out  1      done && err_count==0
//  err_count  out  ERR_W  mismatches this run, saturating at 2^ERR_W-1
//  fail_vec   out  4      sticky per-vector fail flag, indexed as EXP_TABLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; every output=0; idx=0; pass_cnt=0; settle_cnt=0.
//  FSM: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE); DONE -> SETTLE on start.
//  IDLE/DONE, start=1 at edge:
//   - idx=0, pass_cnt=0, err_count=0, fail_vec=0, done=0
//   - {dut_a,dut_b}=2'b00, busy=1, settle_cnt=SETTLE_CYCLES-1, go SETTLE
//  SETTLE: inputs held; settle_cnt decrements each edge; go SAMPLE at the edge where it is 0.
//  SAMPLE (one cycle), compare at exit edge:
//   - mismatch = (dut_f !== EXP_TABLE[idx]); x/z on dut_f counts as mismatch
//   - on mismatch: err_count++ (hold at max), fail_vec[idx]=1
//   - if idx==3 && pass_cnt==NUM_PASSES-1: go DONE, busy=0, done=1; dut_a/b return to 0
//   - else: idx=idx+1 mod 4 (pass_cnt++ on wrap 3->0), drive new {dut_a,dut_b}=idx, reload settle_cnt, go SETTLE
//  Latency: done rises 4*NUM_PASSES*(SETTLE_CYCLES+1) edges after the start-capture edge.
//  Boundaries:
//   - start while busy: ignored
//   - start=1 held in DONE: immediate restart (done drops next edge)
//   - start=1 held in IDLE: one run, then restarts from DONE
//   - err_count saturates without wrap
//   - pass is 0 whenever done is 0
//   - rst_n low mid-run: aborts immediately, no partial result retained
//  dut_a/dut_b change only on clk edges, never in SAMPLE.
// STRUCTURE
//  Shared include gate_chk_defs.vh:
//   - state encodings (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3)
//   - truth-table constants TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110
//  One natural sub-module: gate_settle_timer (loadable down-counter, zero flag).
//  GUT is not instantiated inside; bench wires dut_a/dut_b/dut_f.
// TESTING
//  1 Correct NAND GUT, defaults, 1-cycle start pulse
//    -> done at edge 12; err_count=0, fail_vec=0, pass=1; dut_a/b seen 00,01,10,11 for 3 cycles each.
//  2 NAND GUT, EXP_TABLE=TT_AND
//    -> err_count=4, fail_vec=4'b1111, pass=0.
//  3 dut_f tied to 1'bz
//    -> err_count=4, fail_vec=4'b1111.
//    dut_f stuck-at-1 with TT_NAND
//    -> err_count=1, fail_vec=4'b1000.
//  4 NUM_PASSES=3, ERR_W=2, stuck-at-1
//    -> err_count saturates at 3, fail_vec=4'b1000.
//    start pulses while busy -> no effect, done at edge 36.
//  5 rst_n low during SETTLE of idx=2
//    -> all outputs 0 same cycle.
//    Release, start again -> clean run, pass=1.
//  6 start held high through DONE
//    -> done high one cycle, then back-to-back run; err_count cleared at restart.

Source files
------------

// File: rtl/gate_truth_checker_pkg.sv
// Shared definitions for the gate truth-table checker:
// FSM state encoding, common truth tables, counter sizing helper.
package gate_truth_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Expected f indexed by {a,b}: bit0 = 00 ... bit3 = 11
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    // Bits needed to hold values 0..n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// Loadable down-counter that stops at zero; zero flag is combinational.
// Ports: clk, rst_n, load, load_val, en (decrement), zero (count == 0).
module gate_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Exhaustive self-timed stimulus/checker for a 2-input gate under test.
// Ports: clk, rst_n, start in; dut_a/dut_b drive the gate, dut_f samples it;
// busy, done, pass, err_count (saturating), fail_vec (sticky per vector) out.
module gate_truth_checker
    import gate_truth_checker_pkg::*;
#(
    parameter logic [3:0] EXP_TABLE     = TT_NAND,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         NUM_PASSES    = 1,
    parameter int         ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int CW = cnt_width(SETTLE_CYCLES);
    localparam int PW = cnt_width(NUM_PASSES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state;
    logic [1:0]       idx;
    logic [PW-1:0]    pass_cnt;
    logic             settle_zero;
    logic             take_start;
    logic             last_vec;
    logic             mismatch;
    logic             reload;
    logic [ERR_W-1:0] err_next;

    assign take_start = start && (state == ST_IDLE || state == ST_DONE);
    assign last_vec   = (idx == 2'd3) && (pass_cnt == PASS_LAST);

    // Case equality: an x or z on dut_f is a mismatch
    assign mismatch = (dut_f !== EXP_TABLE[idx]);

    assign err_next = (mismatch && err_count != ERR_MAX)
                    ? err_count + 1'b1 : err_count;

    assign reload = take_start || (state == ST_SAMPLE && !last_vec);

    gate_settle_timer #(
        .W(CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (reload),
        .load_val (SETTLE_LOAD),
        .en       (state == ST_SETTLE),
        .zero     (settle_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            pass_cnt  <= '0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= 4'b0000;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx       <= 2'd0;
                        pass_cnt  <= '0;
                        err_count <= '0;
                        fail_vec  <= 4'b0000;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        dut_a     <= 1'b0;
                        dut_b     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_zero) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch) begin
                        fail_vec[idx] <= 1'b1;
                    end
                    if (last_vec) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                    end else begin
                        idx            <= idx + 2'd1;
                        {dut_a, dut_b} <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                        state <= ST_SETTLE;
                    end
                end
            endcase
        end
    end

endmodule
